yarp_mem_arbiter: RTL and testbench

Sequencer and arbiter that shares the single YARP memory port between instruction fetch and the load/store unit. Accepts one outstanding transaction at a time, prioritises data accesses with a bounded-streak anti-starvation rule for fetch, and routes the response back to the owner. Sits between fetch/LSU and the memory interface. Its `dm_busy_o` drives the decode stage's d-cache-busy stall input, which holds the decoded immediate.

---
 rtl/yarp_pkg.sv | 18 +
 rtl/yarp_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_yarp_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/yarp_pkg.sv
// Shared YARP types and constants used by the memory-port arbiter.
package yarp_pkg;

  localparam int ARB_STREAK_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_DMEM = 1'b0,
    OWN_IMEM = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/yarp_mem_arbiter.sv
// Shares the single YARP memory port between fetch and the LSU: one outstanding
// command, data-first priority with a bounded data streak so fetch cannot starve.
module yarp_mem_arbiter
  import yarp_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_busy_o,
  input  logic        dm_req_i,
  input  logic        dm_wr_i,
  input  logic [31:0] dm_addr_i,
  input  logic [3:0]  dm_byte_en_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_rvalid_o,
  output logic [31:0] dm_rdata_o,
  output logic        dm_busy_o,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_byte_en_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [ARB_STREAK_W-1:0] STREAK_MAX = ARB_STREAK_W'(MAX_D_STREAK);

  arb_state_t               state_reg;
  arb_owner_t               owner_reg;
  arb_owner_t               pick_owner;
  logic                     pick_valid;
  logic [ARB_STREAK_W-1:0]  streak_reg;
  logic [31:0]              rdata_reg;

  // Data wins unless fetch is also waiting and data has used up its streak.
  always_comb begin
    pick_valid = if_req_i | dm_req_i;
    pick_owner = OWN_DMEM;
    if (if_req_i && (!dm_req_i || streak_reg == STREAK_MAX)) begin
      pick_owner = OWN_IMEM;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= ARB_IDLE;
      owner_reg     <= OWN_DMEM;
      streak_reg    <= '0;
      rdata_reg     <= '0;
      mem_req_o     <= 1'b0;
      mem_wr_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_byte_en_o <= '0;
      mem_wdata_o   <= '0;
      if_rvalid_o   <= 1'b0;
      dm_rvalid_o   <= 1'b0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (pick_valid) begin
            owner_reg <= pick_owner;
            mem_req_o <= 1'b1;
            state_reg <= ARB_ISSUE;
            if (pick_owner == OWN_IMEM) begin
              mem_wr_o      <= 1'b0;
              mem_addr_o    <= if_addr_i;
              mem_byte_en_o <= 4'hF;
              mem_wdata_o   <= '0;
              streak_reg    <= '0;
            end else begin
              mem_wr_o      <= dm_wr_i;
              mem_addr_o    <= dm_addr_i;
              mem_byte_en_o <= dm_byte_en_i;
              mem_wdata_o   <= dm_wdata_i;
              if (!if_req_i) begin
                streak_reg <= '0;
              end else if (streak_reg != STREAK_MAX) begin
                streak_reg <= streak_reg + 1'b1;
              end
            end
          end
        end
        ARB_ISSUE: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            if (mem_rvalid_i) begin
              rdata_reg   <= mem_rdata_i;
              if_rvalid_o <= (owner_reg == OWN_IMEM);
              dm_rvalid_o <= (owner_reg == OWN_DMEM);
              state_reg   <= ARB_RESP;
            end else begin
              state_reg <= ARB_WAIT;
            end
          end
        end
        ARB_WAIT: begin
          if (mem_rvalid_i) begin
            rdata_reg   <= mem_rdata_i;
            if_rvalid_o <= (owner_reg == OWN_IMEM);
            dm_rvalid_o <= (owner_reg == OWN_DMEM);
            state_reg   <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          if_rvalid_o <= 1'b0;
          dm_rvalid_o <= 1'b0;
          state_reg   <= ARB_IDLE;
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  assign if_rdata_o = rdata_reg;
  assign dm_rdata_o = rdata_reg;
  assign if_busy_o  = if_req_i & ~if_rvalid_o;
  assign dm_busy_o  = dm_req_i & ~dm_rvalid_o;

  // The owning master must keep its request up until its response strobe.
  owner_holds_req: assert property (@(posedge clk) disable iff (!reset_n)
    (state_reg != ARB_IDLE) |-> ((owner_reg == OWN_IMEM) ? if_req_i : dm_req_i));

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Directed plus randomized bench for yarp_mem_arbiter with a transaction-level
// arbitration model and a behavioural memory responder.
module tb_yarp_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk;
  logic        reset_n;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_busy_o;
  logic        dm_req_i;
  logic        dm_wr_i;
  logic [31:0] dm_addr_i;
  logic [3:0]  dm_byte_en_i;
  logic [31:0] dm_wdata_i;
  logic        dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        dm_busy_o;
  logic        mem_req_o;
  logic        mem_wr_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_byte_en_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  yarp_mem_arbiter #(.MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rvalid_o(if_rvalid_o),
    .if_rdata_o(if_rdata_o), .if_busy_o(if_busy_o),
    .dm_req_i(dm_req_i), .dm_wr_i(dm_wr_i), .dm_addr_i(dm_addr_i),
    .dm_byte_en_i(dm_byte_en_i), .dm_wdata_i(dm_wdata_i),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o), .dm_busy_o(dm_busy_o),
    .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
    .mem_byte_en_o(mem_byte_en_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: who is served, what was asked, what came back.
  bit          inflight, resp_now, resp_next, prev_idle, done_if, done_dm;
  int          owner;          // 0 = data, 1 = fetch
  int          streak;
  logic [31:0] resp_data;
  bit          c_wr;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_be;
  int          ph, cnt, g_dly, r_dly;
  bit          fixed_dly, force_stray, auto_mode;
  int          fix_g, fix_r;
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] grant_addr [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h100 + 32'(4 * $urandom_range(0, 7));
  endfunction

  task automatic deliver();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = resp_data;
    ph           = 0;
    inflight     = 1'b0;
    resp_next    = 1'b1;
  endtask

  task automatic tick();
    bit          exp_issue, fetch_turn, idle_now, owned_if, owned_dm;
    logic [31:0] merged;
    @(negedge clk);
    if (!reset_n) begin
      inflight = 0; resp_next = 0; streak = 0; ph = 0; prev_idle = 1;
      owner = 0; done_if = 0; done_dm = 0;
    end
    resp_now  = resp_next;
    resp_next = 1'b0;

    exp_issue = reset_n && prev_idle && (if_req_i || dm_req_i);
    chk("issue", mem_req_o && !inflight, exp_issue);
    if (exp_issue) begin
      fetch_turn = if_req_i && (!dm_req_i || streak == MAXS);
      if (fetch_turn) begin
        owner = 1; c_wr = 0; c_addr = if_addr_i; c_be = 4'hF; c_wdata = 0;
        streak = 0;
      end else begin
        owner = 0; c_wr = dm_wr_i; c_addr = dm_addr_i; c_be = dm_byte_en_i; c_wdata = dm_wdata_i;
        streak = if_req_i ? ((streak < MAXS) ? streak + 1 : streak) : 0;
      end
      grant_addr.push_back(mem_addr_o);
      inflight = 1; ph = 1; cnt = 0;
      g_dly = fixed_dly ? fix_g : $urandom_range(0, 3);
      r_dly = fixed_dly ? fix_r : $urandom_range(0, 3);
    end

    chk("if_rvalid", if_rvalid_o, resp_now && owner == 1);
    chk("dm_rvalid", dm_rvalid_o, resp_now && owner == 0);
    if (resp_now) begin
      chk("if_rdata", if_rdata_o, resp_data);
      chk("dm_rdata", dm_rdata_o, resp_data);
      if (owner == 1) done_if = 1; else done_dm = 1;
    end
    chk("if_busy", if_busy_o, if_req_i && !(resp_now && owner == 1));
    chk("dm_busy", dm_busy_o, dm_req_i && !(resp_now && owner == 0));
    idle_now = !inflight && !resp_now;

    // Memory responder: grant after g_dly cycles, respond r_dly cycles after grant.
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
    if (ph == 1) begin
      chk("hold_req", mem_req_o, 1'b1);
      chk("hold_wr", mem_wr_o, c_wr);
      chk("hold_addr", mem_addr_o, c_addr);
      if (owner == 0) begin
        chk("hold_be", mem_byte_en_o, c_be);
        chk("hold_wdata", mem_wdata_o, c_wdata);
      end
      if (cnt == g_dly) begin
        mem_gnt_i = 1'b1;
        if (c_wr) begin
          merged = mem_read(c_addr);
          for (int b = 0; b < 4; b++) if (c_be[b]) merged[8*b +: 8] = c_wdata[8*b +: 8];
          mem_model[c_addr] = merged;
        end
        resp_data = mem_read(c_addr);
        if (r_dly == 0) deliver();
        else begin ph = 2; cnt = 0; end
      end else begin
        cnt++;
      end
    end else if (ph == 2) begin
      chk("wait_req_low", mem_req_o, 1'b0);
      cnt++;
      if (cnt == r_dly) deliver();
    end else if (force_stray) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hBAD0_0001;
      force_stray  = 1'b0;
    end
    prev_idle = idle_now;

    if (auto_mode) begin
      owned_if = (owner == 1) && (inflight || resp_next || resp_now);
      owned_dm = (owner == 0) && (inflight || resp_next || resp_now);
      if (!owned_if) begin
        if (!if_req_i) begin
          if ($urandom_range(0, 9) < 4) begin if_req_i = 1; if_addr_i = rand_addr(); end
        end else if (done_if) begin
          if ($urandom_range(0, 9) < 7) if_addr_i = rand_addr(); else if_req_i = 0;
        end else if ($urandom_range(0, 9) == 0) begin
          if_req_i = 0;
        end
        done_if = 0;
      end
      if (!owned_dm) begin
        if (!dm_req_i || done_dm) begin
          if ((dm_req_i && $urandom_range(0, 9) < 7) || (!dm_req_i && $urandom_range(0, 9) < 5)) begin
            dm_req_i = 1; dm_wr_i = 1'($urandom_range(0, 1)); dm_addr_i = rand_addr();
            dm_byte_en_i = 4'($urandom_range(1, 15)); dm_wdata_i = $urandom;
          end else begin
            dm_req_i = 0;
          end
        end else if ($urandom_range(0, 9) == 0) begin
          dm_req_i = 0;
        end
        done_dm = 0;
      end
    end
  endtask

  task automatic wait_rv(input bit fetch, input int max, output int n);
    bit got;
    got = 0; n = 0;
    while (!got && n < max) begin
      tick();
      n++;
      got = fetch ? if_rvalid_o : dm_rvalid_o;
    end
    chk(fetch ? "if_rvalid_seen" : "dm_rvalid_seen", got, 1'b1);
  endtask

  initial begin
    int n;
    reset_n = 0; if_req_i = 0; if_addr_i = 0; dm_req_i = 0; dm_wr_i = 0;
    dm_addr_i = 0; dm_byte_en_i = 0; dm_wdata_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    auto_mode = 0; fixed_dly = 1; fix_g = 0; fix_r = 1; force_stray = 0; prev_idle = 1;

    repeat (3) tick();
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_wr", mem_wr_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_be", mem_byte_en_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk("rst_rdata", dm_rdata_o, 0);
    reset_n = 1;
    tick();

    // Single load with gnt next cycle and data the cycle after.
    mem_model[32'h100] = 32'hDEADBEEF;
    dm_req_i = 1; dm_wr_i = 0; dm_addr_i = 32'h100; dm_byte_en_i = 4'hF; dm_wdata_i = 0;
    #1 chk("load_busy_c0", dm_busy_o, 1);
    wait_rv(0, 8, n);
    chk("load_latency", n, 3);
    chk("load_data", dm_rdata_o, 32'hDEADBEEF);
    tick(); dm_req_i = 0; tick();

    // Collision: store goes first, fetch right after.
    if_req_i = 1; if_addr_i = 0;
    dm_req_i = 1; dm_wr_i = 1; dm_addr_i = 32'h200; dm_byte_en_i = 4'b0011; dm_wdata_i = 32'h1234;
    tick();
    chk("coll_first_wr", mem_wr_o, 1);
    chk("coll_first_addr", mem_addr_o, 32'h200);
    wait_rv(0, 10, n);
    tick(); dm_req_i = 0;
    tick();
    chk("coll_fetch_req", mem_req_o, 1);
    chk("coll_fetch_addr", mem_addr_o, 32'h0);
    wait_rv(1, 10, n);
    chk("coll_fetch_data", if_rdata_o, 32'h0000FFFF);
    tick(); if_req_i = 0; tick();

    // Starvation: both held, expect D D D D F repeating.
    if_req_i = 1; if_addr_i = 32'h1000;
    dm_req_i = 1; dm_wr_i = 0; dm_addr_i = 32'h2000; dm_byte_en_i = 4'hF;
    grant_addr.delete();
    n = 0;
    while (grant_addr.size() < 10 && n < 100) begin tick(); n++; end
    chk("starve_grants", grant_addr.size(), 10);
    for (int i = 0; i < grant_addr.size(); i++)
      chk($sformatf("starve_grant%0d", i), grant_addr[i], (i % 5 == 4) ? 32'h1000 : 32'h2000);
    wait_rv(1, 10, n);
    tick(); if_req_i = 0; dm_req_i = 0; tick();

    // Slow grant, then gnt and rvalid together.
    fix_g = 5; fix_r = 0;
    dm_req_i = 1; dm_wr_i = 0; dm_addr_i = 32'h104;
    tick();
    chk("slow_req0", mem_req_o, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("slow_req", mem_req_o, 1);
      chk("slow_addr", mem_addr_o, 32'h104);
    end
    tick();
    chk("slow_rvalid", dm_rvalid_o, 1);
    chk("slow_data", dm_rdata_o, 32'h0104FEFB);
    tick(); dm_req_i = 0; tick();

    // Reset while waiting for the response, then a stray rvalid in IDLE.
    fix_g = 0; fix_r = 6;
    dm_req_i = 1; dm_addr_i = 32'h108;
    tick(); tick(); tick();
    reset_n = 0; dm_req_i = 0;
    tick();
    chk("rst2_mem_req", mem_req_o, 0);
    chk("rst2_mem_addr", mem_addr_o, 0);
    chk("rst2_dm_rvalid", dm_rvalid_o, 0);
    chk("rst2_rdata", dm_rdata_o, 0);
    reset_n = 1; force_stray = 1;
    tick(); tick();
    chk("stray_dm_rvalid", dm_rvalid_o, 0);
    chk("stray_if_rvalid", if_rvalid_o, 0);
    chk("stray_mem_req", mem_req_o, 0);

    // Randomized traffic against the model.
    fixed_dly = 0; auto_mode = 1;
    repeat (800) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
